// File: rtl/byte_stream_pkg.sv
// rtl/byte_stream_pkg.sv - shared types, occupancy states and pointer-width helper for the byte FIFO
package byte_stream_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_t;

    localparam int DEFAULT_DEPTH = 4;

    // One extra MSB lets equal indices be told apart as full versus empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// rtl/fifo_wrap_ptr.sv - wrapping FIFO pointer counting modulo 2*DEPTH
module fifo_wrap_ptr
    import byte_stream_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      inc,
    output logic [ptr_w(DEPTH)-1:0]   ptr
);

    localparam int PW = ptr_w(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PW'(1);
        end
    end

endmodule

// File: rtl/byte_stream_fifo.sv
// rtl/byte_stream_fifo.sv - valid/ready byte FIFO with occupancy count and synchronous flush
module byte_stream_fifo
    import byte_stream_pkg::*;
#(
    parameter int    DEPTH   = DEFAULT_DEPTH,
    parameter byte_t RST_VAL = 8'h00
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  byte_t                      in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output byte_t                      out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PW     = ptr_w(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("byte_stream_fifo: DEPTH must be a power of two and at least 2");
    end
    if ($bits(byte_t) != 8) begin : g_width_check
        $error("byte_stream_fifo: byte_t must be 8 bits wide");
    end

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     occ_cnt;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic              ptr_full;
    logic              ptr_empty;
    logic              push;
    logic              pop;
    occ_t              occ;
    byte_t             rd_view [DEPTH];

    assign wr_idx    = wr_ptr[ADDR_W-1:0];
    assign rd_idx    = rd_ptr[ADDR_W-1:0];
    assign ptr_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_idx == rd_idx);
    assign ptr_empty = (wr_ptr == rd_ptr);

    always_comb begin
        occ = OCC_PARTIAL;
        if (ptr_empty) begin
            occ = OCC_EMPTY;
        end else if (ptr_full) begin
            occ = OCC_FULL;
        end
    end

    // No write-through: a full FIFO refuses input even when the head is popped this cycle.
    assign in_ready  = (occ != OCC_FULL) & ~rst;
    assign out_valid = (occ != OCC_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign occ_cnt = wr_ptr - rd_ptr;
    assign count   = CW'(occ_cnt);

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (push & ~flush),
        .ptr   (wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (pop & ~flush),
        .ptr   (rd_ptr)
    );

    // Storage needs no reset: an entry is only ever read after it has been written.
    for (genvar i = 0; i < DEPTH; i++) begin : blk
        byte_t q;
        always_ff @(posedge clk) begin
            if (push && (wr_idx == ADDR_W'(i))) begin
                q <= in_data;
            end
        end
        assign rd_view[i] = q;
    end

    assign out_data = out_valid ? rd_view[rd_idx] : RST_VAL;

endmodule

// File: tb/tb_byte_stream_fifo.sv
// tb/tb_byte_stream_fifo.sv - directed and scoreboarded checks of byte_stream_fifo at DEPTH 4 and 2
module tb_byte_stream_fifo;

    localparam logic [7:0] RV4 = 8'hE7;
    localparam logic [7:0] RV2 = 8'h5A;

    logic       clk;
    logic       rst;

    logic       flush4, in_valid4, in_ready4, out_valid4, out_ready4;
    logic [7:0] in_data4, out_data4;
    logic [2:0] count4;

    logic       flush2, in_valid2, in_ready2, out_valid2, out_ready2;
    logic [7:0] in_data2, out_data2;
    logic [1:0] count2;

    int pass_cnt = 0;
    int total    = 0;

    byte_stream_fifo #(.DEPTH(4), .RST_VAL(RV4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush4),
        .in_valid  (in_valid4),
        .in_data   (in_data4),
        .in_ready  (in_ready4),
        .out_valid (out_valid4),
        .out_data  (out_data4),
        .out_ready (out_ready4),
        .count     (count4)
    );

    byte_stream_fifo #(.DEPTH(2), .RST_VAL(RV2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush2),
        .in_valid  (in_valid2),
        .in_data   (in_data2),
        .in_ready  (in_ready2),
        .out_valid (out_valid2),
        .out_data  (out_data2),
        .out_ready (out_ready2),
        .count     (count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock on dut4 with the given inputs, then inputs return to idle.
    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
        in_valid4  = v;
        in_data4   = d;
        out_ready4 = r;
        flush4     = f;
        @(posedge clk);
        #1;
        in_valid4  = 1'b0;
        in_data4   = 8'h00;
        out_ready4 = 1'b0;
        flush4     = 1'b0;
    endtask

    logic [7:0] exp_q[$];
    int         mcnt;
    logic       v, r, pe, po;
    logic [7:0] d;

    initial begin
        rst = 1'b1;
        flush4 = 0; in_valid4 = 0; in_data4 = 0; out_ready4 = 0;
        flush2 = 0; in_valid2 = 0; in_data2 = 0; out_ready2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready4, 0);
        chk("rst_count", count4, 0);
        chk("rst_out_valid", out_valid4, 0);
        chk("rst_out_data", out_data4, RV4);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready4, 1);

        // Three pushes with the consumer stalled
        cyc(1, 8'h11, 0, 0);
        chk("t1_first_latency_valid", out_valid4, 1);
        chk("t1_first_latency_data", out_data4, 8'h11);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        chk("t1_count", count4, 3);
        chk("t1_head", out_data4, 8'h11);
        chk("t1_in_ready", in_ready4, 1);
        chk("t1_drain0", out_data4, 8'h11); cyc(0, 0, 1, 0);
        chk("t1_drain1", out_data4, 8'h22); cyc(0, 0, 1, 0);
        chk("t1_drain2", out_data4, 8'h33); cyc(0, 0, 1, 0);
        chk("t1_empty", count4, 0);

        // Fill, then push+pop while full: only the pop happens
        for (int i = 0; i < 4; i++) cyc(1, 8'hA0 + 8'(i), 0, 0);
        chk("t2_count_full", count4, 4);
        chk("t2_in_ready_full", in_ready4, 0);
        chk("t2_out_valid_full", out_valid4, 1);
        cyc(1, 8'hBB, 1, 0);
        chk("t2_count_after", count4, 3);
        chk("t2_head_after", out_data4, 8'hA1);
        chk("t2_in_ready_after", in_ready4, 1);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("t2_drain%0d", i), out_data4, 8'hA0 + 8'(i));
            cyc(0, 0, 1, 0);
        end
        chk("t2_empty", out_valid4, 0);

        // Streaming push+pop across pointer wrap
        cyc(1, 8'h00, 0, 0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t3_data%0d", i), out_data4, 8'(i));
            cyc(i < 9, 8'(i + 1), 1, 0);
            chk($sformatf("t3_count%0d", i), count4, (i < 9) ? 1 : 0);
        end

        // Flush overrides a simultaneous push and pop
        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h02, 0, 0);
        chk("t4_count_pre", count4, 2);
        cyc(1, 8'hFF, 1, 1);
        chk("t4_count", count4, 0);
        chk("t4_out_valid", out_valid4, 0);
        chk("t4_out_data", out_data4, RV4);
        cyc(1, 8'h03, 0, 0);
        chk("t4_next_data", out_data4, 8'h03);
        chk("t4_next_count", count4, 1);
        cyc(0, 0, 1, 0);

        // Asynchronous reset mid-cycle
        cyc(1, 8'h31, 0, 0);
        cyc(1, 8'h32, 0, 0);
        cyc(1, 8'h33, 0, 0);
        chk("t5_count_pre", count4, 3);
        #3 rst = 1'b1;
        #1;
        chk("t5_out_valid", out_valid4, 0);
        chk("t5_count", count4, 0);
        chk("t5_in_ready", in_ready4, 0);
        chk("t5_out_data", out_data4, RV4);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_in_ready_after", in_ready4, 1);
        chk("t5_count_after", count4, 0);

        // DEPTH=2 random traffic against a queue model
        mcnt = 0;
        for (int c = 0; c < 1000; c++) begin
            chk("t6_count", count2, mcnt);
            chk("t6_in_ready", in_ready2, mcnt != 2);
            chk("t6_out_valid", out_valid2, mcnt != 0);
            chk("t6_out_data", out_data2, (mcnt != 0) ? exp_q[0] : RV2);
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            in_valid2  = v;
            in_data2   = d;
            out_ready2 = r;
            pe = v && (mcnt < 2);
            po = r && (mcnt > 0);
            @(posedge clk);
            #1;
            if (po) void'(exp_q.pop_front());
            if (pe) exp_q.push_back(d);
            mcnt = exp_q.size();
        end
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
